// File: rtl/clk_div_ctrl_if.sv
// clk_div_ctrl_if: divisor configuration channel (valid/ready transfer plus rejection pulse).
interface clk_div_ctrl_if #(parameter int WIDTH = 30);
   logic             cfg_valid;
   logic [WIDTH-1:0] cfg_n;
   logic             cfg_ready;
   logic             cfg_err;
   modport master (output cfg_valid, cfg_n, input cfg_ready, cfg_err);
   modport slave (input cfg_valid, cfg_n, output cfg_ready, cfg_err);
endinterface

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: run/stop and period-boundary divisor reconfiguration for the programmable divider.
// Define CLK_DIV_CTRL_GRACEFUL_STOP_EN to finish the current period before stopping.
module clk_div_ctrl #(
   parameter int               WIDTH     = 30,
   parameter logic [WIDTH-1:0] N_DEFAULT = WIDTH'(2000001),
   parameter logic [WIDTH-1:0] N_MIN     = WIDTH'(2)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             run,
   clk_div_ctrl_if.slave    cfg,
   output logic [WIDTH-1:0] cur_n,
   output logic             active,
   output logic             tick,
   output logic             div_out
);
   typedef enum logic [1:0] {IDLE, RUN, PEND, STOP} state_t;
   state_t           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d, cur_n_q, cur_n_d, pend_n_q, pend_n_d, nxt;
   logic             tick_q, tick_d, div_q, div_d, err_q, err_d;
   logic             acc, good, last;
`ifdef CLK_DIV_CTRL_GRACEFUL_STOP_EN
   logic             pend_vld_q, pend_vld_d;
`endif
   always_comb begin
      acc      = cfg.cfg_valid & cfg.cfg_ready;
      err_d    = acc & (cfg.cfg_n < N_MIN);
      good     = acc & ~err_d;
      last     = cnt_q == cur_n_q - 1'b1;
      nxt      = last ? '0 : cnt_q + 1'b1;
      state_d  = state_q;
      cnt_d    = nxt;
      cur_n_d  = cur_n_q;
      pend_n_d = pend_n_q;
`ifdef CLK_DIV_CTRL_GRACEFUL_STOP_EN
      pend_vld_d = pend_vld_q;
`endif
      unique case (state_q)
         IDLE: begin
            cnt_d   = '0;
            cur_n_d = good ? cfg.cfg_n : cur_n_q;
            state_d = run ? RUN : IDLE;
         end
         RUN: begin
            // a divisor arriving on the last count can be used by the very next period
            cur_n_d  = good && last ? cfg.cfg_n : cur_n_q;
            pend_n_d = good && !last ? cfg.cfg_n : pend_n_q;
            state_d  = good && !last ? PEND : RUN;
            if (!run) begin
`ifdef CLK_DIV_CTRL_GRACEFUL_STOP_EN
               pend_vld_d = good && !last;
               state_d    = last ? IDLE : STOP;
`else
               state_d = IDLE;
               cnt_d   = '0;
               cur_n_d = good ? cfg.cfg_n : cur_n_q;
`endif
            end
         end
         PEND: begin
            cur_n_d = last ? pend_n_q : cur_n_q;
            state_d = last ? RUN : PEND;
            if (!run) begin
`ifdef CLK_DIV_CTRL_GRACEFUL_STOP_EN
               pend_vld_d = !last;
               state_d    = last ? IDLE : STOP;
`else
               state_d = IDLE;
               cnt_d   = '0;
               cur_n_d = pend_n_q;
`endif
            end
         end
`ifdef CLK_DIV_CTRL_GRACEFUL_STOP_EN
         STOP: begin
            cur_n_d    = last && pend_vld_q ? pend_n_q : cur_n_q;
            pend_vld_d = pend_vld_q && !last && !run;
            state_d    = last ? (run ? RUN : IDLE) : (run ? (pend_vld_q ? PEND : RUN) : STOP);
         end
`endif
         default: state_d = IDLE;
      endcase
      tick_d = state_d != IDLE && cnt_d == '0;
      div_d  = state_d != IDLE && cnt_d < (cur_n_d >> 1);
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         cur_n_q  <= N_DEFAULT;
         pend_n_q <= '0;
         tick_q   <= 1'b0;
         div_q    <= 1'b0;
         err_q    <= 1'b0;
`ifdef CLK_DIV_CTRL_GRACEFUL_STOP_EN
         pend_vld_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         cur_n_q  <= cur_n_d;
         pend_n_q <= pend_n_d;
         tick_q   <= tick_d;
         div_q    <= div_d;
         err_q    <= err_d;
`ifdef CLK_DIV_CTRL_GRACEFUL_STOP_EN
         pend_vld_q <= pend_vld_d;
`endif
      end
   assign cfg.cfg_ready = state_q == IDLE || state_q == RUN;
   assign cfg.cfg_err   = err_q;
   assign cur_n         = cur_n_q;
   assign active        = state_q != IDLE;
   assign tick          = tick_q;
   assign div_out       = div_q;
endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: directed stimulus with a tick/error scoreboard for clk_div_ctrl.
module tb_clk_div_ctrl;
   localparam int W  = 30;
   localparam int ND = 5;
   typedef struct {int n; bit first;} rec_t;
   logic          clk = 1'b0;
   logic          reset_n, run;
   logic [W-1:0]  cur_n;
   logic          active, tick, div_out;
   int            checks = 0, errors = 0;
   rec_t          tq[$];
   int            eq[$];
   rec_t          mon_r;
   int            phase = 0, last_n = 0;
   bit            have = 1'b0;
   clk_div_ctrl_if #(.WIDTH(W)) cfg_if ();
   clk_div_ctrl #(.WIDTH(W), .N_DEFAULT(W'(ND)), .N_MIN(W'(2))) dut (
      .clk(clk), .reset_n(reset_n), .run(run), .cfg(cfg_if),
      .cur_n(cur_n), .active(active), .tick(tick), .div_out(div_out)
   );
   always #5 clk = ~clk;
   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
      end
   endtask
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic push(input int n, input bit first);
      rec_t r;
      r.n = n;
      r.first = first;
      tq.push_back(r);
   endtask
   task automatic offer(input int n);
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_n = W'(n);
   endtask
   // Monitor: every tick consumes one expected period record; every cfg_err one expected divisor.
   always @(negedge clk) begin
      if (tick) begin
         if (tq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tick_unexpected: got tick with cur_n %0d want no tick at %0t", cur_n, $time);
         end else begin
            mon_r = tq.pop_front();
            chk("tick_cur_n", int'(cur_n), mon_r.n);
            if (!mon_r.first) chk("tick_spacing", phase, last_n);
            last_n = mon_r.n;
            phase = 0;
            have = 1'b1;
         end
      end
      if (active && have) begin
         chk("div_out", int'(div_out), int'(phase < last_n / 2));
         phase++;
      end
      if (!active) have = 1'b0;
      if (cfg_if.cfg_err) begin
         if (eq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL err_unexpected: got cfg_err with cur_n %0d want none at %0t", cur_n, $time);
         end else chk("err_cur_n", int'(cur_n), eq.pop_front());
      end
   end
   initial begin
      reset_n = 1'b0;
      run = 1'b0;
      cfg_if.cfg_valid = 1'b0;
      cfg_if.cfg_n = '0;
      step(2);
      chk("rst_ready", int'(cfg_if.cfg_ready), 1);
      chk("rst_err", int'(cfg_if.cfg_err), 0);
      chk("rst_cur_n", int'(cur_n), ND);
      chk("rst_active", int'(active), 0);
      chk("rst_tick", int'(tick), 0);
      chk("rst_div", int'(div_out), 0);
      reset_n = 1'b1;
      step(1);
      // N=5 from reset: ticks at cycles 1, 6, 11, then immediate stop at cnt=4
      push(5, 1); push(5, 0); push(5, 0);
      run = 1'b1;
      step(15);
      run = 1'b0;
      step(1);
      chk("stopA_active", int'(active), 0);
      chk("stopA_div", int'(div_out), 0);
      // start together with cfg 4: ticks 1,5 (N4), 9,16 (N7), 23,29,35 (N6), 41 (N8), 49 (N3), 52 (N10)
      push(4, 1); push(4, 0); push(7, 0); push(7, 0); push(6, 0);
      push(6, 0); push(6, 0); push(8, 0); push(3, 0); push(10, 0);
      offer(4);
      run = 1'b1;
      step(1);
      cfg_if.cfg_valid = 1'b0;
      step(5);
      chk("ready_cnt1", int'(cfg_if.cfg_ready), 1);
      offer(7);
      step(1);
      cfg_if.cfg_valid = 1'b0;
      chk("pend_ready_1", int'(cfg_if.cfg_ready), 0);
      step(1);
      chk("pend_ready_2", int'(cfg_if.cfg_ready), 0);
      step(1);
      chk("pend_ready_back", int'(cfg_if.cfg_ready), 1);
      step(13);
      offer(6);
      step(1);
      cfg_if.cfg_valid = 1'b0;
      chk("bnd6_ready", int'(cfg_if.cfg_ready), 1);
      offer(1);
      eq.push_back(6);
      step(1);
      cfg_if.cfg_valid = 1'b0;
      chk("rej_err_pulse", int'(cfg_if.cfg_err), 1);
      chk("rej_ready", int'(cfg_if.cfg_ready), 1);
      step(1);
      chk("rej_err_low", int'(cfg_if.cfg_err), 0);
      step(15);
      offer(8);
      step(1);
      cfg_if.cfg_valid = 1'b0;
      step(7);
      offer(3);
      step(1);
      cfg_if.cfg_valid = 1'b0;
      chk("bnd3_ready", int'(cfg_if.cfg_ready), 1);
      step(2);
      offer(10);
      step(1);
      cfg_if.cfg_valid = 1'b0;
      step(1);
      offer(4);
      step(1);
      cfg_if.cfg_valid = 1'b0;
      chk("pend4_ready", int'(cfg_if.cfg_ready), 0);
      step(2);
      // reset in the middle of PEND discards the pending 4
      reset_n = 1'b0;
      #1;
      chk("mid_rst_cur_n", int'(cur_n), ND);
      chk("mid_rst_active", int'(active), 0);
      chk("mid_rst_ready", int'(cfg_if.cfg_ready), 1);
      step(2);
      push(5, 1); push(5, 0); push(5, 0); push(6, 0);
      reset_n = 1'b1;
      step(1);
      chk("restart_tick", int'(tick), 1);
      chk("restart_cur_n", int'(cur_n), ND);
      step(14);
      offer(6);
      step(1);
      cfg_if.cfg_valid = 1'b0;
      step(2);
      run = 1'b0;
      step(1);
`ifdef CLK_DIV_CTRL_GRACEFUL_STOP_EN
      chk("gstop_active_1", int'(active), 1);
      step(1);
      chk("gstop_active_2", int'(active), 1);
      step(1);
      chk("gstop_active_3", int'(active), 1);
      step(1);
      chk("gstop_active_off", int'(active), 0);
      chk("gstop_tick", int'(tick), 0);
`else
      chk("stop_active", int'(active), 0);
      chk("stop_tick", int'(tick), 0);
      chk("stop_div", int'(div_out), 0);
`endif
      step(3);
      chk("ticks_left", tq.size(), 0);
      chk("errs_left", eq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
